// File: rtl/bla_pkg.sv
// Shared types and constants for the sequential nibble-serial subtractor.
package bla_pkg;
   localparam int SLICE_W = 4;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
endpackage

// File: rtl/bla_sub4.sv
// 4-bit subtract slice with look-ahead borrow: d4 = a4 - b4 - br_in.
module bla_sub4
   import bla_pkg::*;
(
   input  logic [SLICE_W-1:0] a4,
   input  logic [SLICE_W-1:0] b4,
   input  logic               br_in,
   output logic [SLICE_W-1:0] d4,
   output logic               br_out
);
   logic [SLICE_W-1:0] g, p;
   logic [SLICE_W-1:0] br;

   // g: bit generates a borrow, p: bit passes an incoming borrow through
   assign g = ~a4 & b4;
   assign p = ~(a4 ^ b4);

   assign br[0] = br_in;
   assign br[1] = g[0] | (p[0] & br_in);
   assign br[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & br_in);
   assign br[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & br_in);

   assign d4 = a4 ^ b4 ^ br;

   assign br_out = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]) |
                   (p[3] & p[2] & p[1] & p[0] & br_in);
endmodule

// File: rtl/bla_sub_seq.sv
// Nibble-serial subtractor: diff = a - b - bin, one 4-bit slice per cycle, LSB first.
// Optional zero/ovf flags are built when BLA_SUB_FLAGS_EN is defined.
module bla_sub_seq
   import bla_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout
`ifdef BLA_SUB_FLAGS_EN
   ,
   output logic             zero,
   output logic             ovf
`endif
);
   localparam int NSL = WIDTH / SLICE_W;
   localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSL - 1);

   state_e            state, state_nxt;
   logic [KW-1:0]     k;
   logic              br;
   logic [WIDTH-1:0]  a_r, b_r;
   logic [WIDTH-1:0]  diff_nxt;
   logic [SLICE_W-1:0] d4;
   logic              br_out;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = RUN;
         end
         RUN:  if (k == K_LAST) state_nxt = DONE;
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   bla_sub4 u_sub4 (
      .a4     (a_r[int'(k)*SLICE_W +: SLICE_W]),
      .b4     (b_r[int'(k)*SLICE_W +: SLICE_W]),
      .br_in  (br),
      .d4     (d4),
      .br_out (br_out)
   );

   // Result register with the current nibble merged in; used for the flags on the last slice
   always_comb begin
      diff_nxt = diff;
      diff_nxt[int'(k)*SLICE_W +: SLICE_W] = d4;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         k    <= '0;
         br   <= 1'b0;
         a_r  <= '0;
         b_r  <= '0;
         diff <= '0;
         bout <= 1'b0;
`ifdef BLA_SUB_FLAGS_EN
         zero <= 1'b0;
         ovf  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               a_r <= a;
               b_r <= b;
               br  <= bin;
               k   <= '0;
            end
            RUN: begin
               diff <= diff_nxt;
               br   <= br_out;
               k    <= k + 1'b1;
               if (k == K_LAST) begin
                  k    <= '0;
                  bout <= br_out;
`ifdef BLA_SUB_FLAGS_EN
                  zero <= (diff_nxt == '0);
                  ovf  <= (a_r[WIDTH-1] != b_r[WIDTH-1]) && (diff_nxt[WIDTH-1] != a_r[WIDTH-1]);
`endif
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/bla_sub_seq.md
BLA_SUB_SEQ -- requirements
Module: bla_sub_seq

Interface
REQ-001: Parameter WIDTH, default 16, is the operand width; it SHALL be a multiple of 4 and at least 4.
REQ-002: clk  input  1  single clock; all logic rising-edge triggered.
REQ-003: rst_n  input  1  reset; synchronous, active-low.
REQ-004: in_valid  input  1  operands a, b, bin are valid.
REQ-005: in_ready  output  1  block can accept operands.
REQ-006: a  input  WIDTH  minuend.
REQ-007: b  input  WIDTH  subtrahend.
REQ-008: bin  input  1  borrow-in.
REQ-009: out_valid  output  1  result valid.
REQ-010: out_ready  input  1  downstream accepts result.
REQ-011: diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012: bout  output  1  borrow-out; 1 when a < b + bin (unsigned).
REQ-013: zero, ovf  output  1 each  flags; present only under BLA_SUB_FLAGS_EN (REQ-031).

Function
REQ-014: FSM states SHALL be IDLE, RUN, DONE.
REQ-015: in_ready SHALL be 1 in IDLE and 0 in RUN and DONE, decoded directly from state.
REQ-016: IDLE->RUN on in_valid && in_ready: a, b, bin latched; slice index k=0; borrow register = bin.
REQ-017: RUN: one 4-bit nibble per cycle, LSB nibble first; nibble k of diff and the borrow register update on each edge; k increments.
REQ-018: Per bit i of the slice: g_i = ~a_i & b_i; p_i = ~(a_i ^ b_i); d_i = a_i ^ b_i ^ br_i; the slice borrow-out SHALL be computed in look-ahead form (g3 | p3 g2 | p3 p2 g1 | p3 p2 p1 g0 | p3 p2 p1 p0 br_in), not rippled.
REQ-019: RUN->DONE on the edge that processes nibble WIDTH/4-1; out_valid SHALL rise exactly WIDTH/4 edges after the accepting edge (4 edges for WIDTH=16).
REQ-020: DONE: out_valid=1; diff, bout and flags SHALL remain stable until out_valid && out_ready.
REQ-021: DONE->IDLE on out_ready; out_valid falls on that edge; in_ready returns to 1 on the same edge (no accept in the same cycle as the result handshake).
REQ-022: in_valid SHALL be ignored outside IDLE; operand changes during RUN SHALL NOT affect the result.
REQ-023: out_ready SHALL be ignored outside DONE.
REQ-024: bout SHALL equal the final slice borrow-out; diff and bout SHALL hold their previous result values in IDLE.
REQ-025: WIDTH=4 SHALL work (single RUN cycle).

Reset
REQ-026: With rst_n=0 at a rising edge: state=IDLE, k=0, out_valid=0, diff=0, bout=0, zero=0, ovf=0, borrow register=0.
REQ-027: Reset during RUN or DONE SHALL abort the operation; no out_valid pulse for it; in_ready=1 on the first cycle after release.
REQ-028: Reset SHALL take priority over all handshakes in the same cycle.

Configuration
REQ-029: Macro BLA_SUB_FLAGS_EN controls the flag logic.
REQ-030: Without it: ports zero and ovf are absent; no flag logic.
REQ-031: With it: zero=1 iff diff==0; ovf=1 iff signed overflow (a[MSB]!=b[MSB] && diff[MSB]!=a[MSB]); both update on the RUN->DONE edge and hold like diff.

Structure
REQ-032: Shared package bla_pkg SHALL hold the FSM state enum (IDLE/RUN/DONE) and constant SLICE_W=4.
REQ-033: The 4-bit combinational slice SHALL be sub-module bla_sub4 (a4, b4, br_in -> d4, br_out) with a single instance in bla_sub_seq.

Verification
REQ-034: WIDTH=16, a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, out_valid 4 edges after accept.
REQ-035: a=0x1234, b=0x1234, bin=0 -> diff=0x0000, bout=0; with BLA_SUB_FLAGS_EN zero=1, ovf=0.
REQ-036: a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0; with BLA_SUB_FLAGS_EN ovf=1, zero=0.
REQ-037: a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0; in_valid held high with new operands during RUN -> ignored.
REQ-038: out_ready held 0 for 5 cycles in DONE -> diff/bout stable, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 the next cycle.
REQ-039: rst_n=0 in the 2nd RUN cycle -> no out_valid, all outputs 0; next operation a=0x00FF, b=0x000F -> diff=0x00F0, bout=0.
